// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants for the instruction fetch stage
package fetch_unit_pkg;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          PC_STEP      = 4;
endpackage

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - DEPTH-entry sync FIFO of {pc, instr} with flush
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [WIDTH-1:0]         o_head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_head  = r_mem[r_rd];
   assign w_pop   = i_pop & ~o_empty;
   // A push on a full FIFO is only taken when the head leaves in the same cycle.
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr] <= i_data;
   end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC, credit-limited imem requests, redirect flush
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC),
   parameter int                    DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = ADDR_WIDTH + DATA_WIDTH;

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [CW-1:0]         r_inflight;
   logic [CW-1:0]         r_drop;
   logic [ADDR_WIDTH-1:0] r_pcq [DEPTH];
   logic [AW-1:0]         r_pcq_wr;
   logic [AW-1:0]         r_pcq_rd;

   logic                  w_pop;
   logic                  w_acc;
   logic                  w_rsp;
   logic                  w_keep;
   logic [CW:0]           w_credit;
   logic                  w_full;
   logic                  w_empty;
   logic [CW-1:0]         w_count;
   logic [FW-1:0]         w_head;

   assign w_pop = instr_valid & instr_ready;
   // Every slot is reserved at request time: outstanding, to-be-dropped and buffered words.
   assign w_credit = (CW+1)'(r_inflight) + (CW+1)'(r_drop) + (CW+1)'(w_count)
                   - (CW+1)'(w_pop);
   assign imem_req_valid = rst_n & (w_credit < (CW+1)'(DEPTH));
   assign imem_req_addr  = r_pc;
   assign w_acc  = imem_req_valid & imem_req_ready;
   assign w_rsp  = imem_rsp_valid & ((r_drop != '0) | (r_inflight != '0));
   assign w_keep = w_rsp & (r_drop == '0) & ~redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
         r_pcq_wr   <= '0;
         r_pcq_rd   <= '0;
      end else if (redirect_valid) begin
         r_pc       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         r_inflight <= '0;
         r_drop     <= r_drop + r_inflight + CW'(w_acc) - CW'(w_rsp);
         r_pcq_wr   <= '0;
         r_pcq_rd   <= '0;
      end else begin
         if (w_acc) begin
            r_pc     <= r_pc + ADDR_WIDTH'(PC_STEP);
            r_pcq_wr <= r_pcq_wr + AW'(1);
         end
         if (w_keep) r_pcq_rd <= r_pcq_rd + AW'(1);
         if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
         r_inflight <= r_inflight + CW'(w_acc) - CW'(w_keep);
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc && !redirect_valid) r_pcq[r_pcq_wr] <= r_pc;
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_keep),
      .i_data  ({r_pcq[r_pcq_rd], imem_rsp_data}),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign instr_valid = ~w_empty;
   assign instr       = w_empty ? DATA_WIDTH'(NOP_INSTR) : w_head[DATA_WIDTH-1:0];
   assign instr_pc    = w_empty ? '0 : w_head[DATA_WIDTH +: ADDR_WIDTH];

   a_rsp_protocol: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> ((r_inflight != '0) || (r_drop != '0)));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (w_keep && w_full) |-> w_pop);
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against an in-order stream model
module tb_fetch_unit;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   always #5 clk = ~clk;

   fetch_unit #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .RESET_PC   (RST_PC),
      .DEPTH      (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] memq[$];
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] exp_req = RST_PC;
   bit          want_ready, want_rsp, want_iready, want_redir;
   logic [31:0] redir_target;
   bit          o_rv, o_fire, o_iv;
   logic [31:0] o_addr, o_ipc;
   int          accs, pops;
   bit          got_first;
   logic [31:0] first_pop;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit rdy, input bit rsp, input bit ir);
      want_ready = rdy; want_rsp = rsp; want_iready = ir; want_redir = 1'b0;
   endtask

   // One clock: drive after the edge, score at the falling edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      imem_req_ready = want_ready;
      instr_ready    = want_iready;
      redirect_valid = want_redir;
      redirect_pc    = redir_target;
      if (want_rsp && memq.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(memq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #4;
      o_rv = imem_req_valid; o_addr = imem_req_addr;
      o_fire = imem_req_valid & imem_req_ready;
      o_iv = instr_valid; o_ipc = instr_pc;
      if (instr_valid && instr_ready) begin
         check_val("instr_pc", instr_pc, exp_pc);
         check_val("instr", instr, mem_word(exp_pc));
         if (!got_first) begin got_first = 1'b1; first_pop = instr_pc; end
         exp_pc += 32'd4;
         pops++;
      end else if (!instr_valid) begin
         check_val("nop_when_empty", instr, NOP);
      end
      if (o_fire) begin
         check_val("req_addr", imem_req_addr, exp_req);
         memq.push_back(imem_req_addr);
         exp_req += 32'd4;
         accs++;
      end
      check_val("outstanding_le_depth", 64'(memq.size() <= DEPTH), 64'd1);
      if (redirect_valid) begin
         exp_pc  = {redirect_pc[31:2], 2'b00};
         exp_req = {redirect_pc[31:2], 2'b00};
         got_first = 1'b0;
      end
      want_redir = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0; instr_ready = 1'b0;
      #1;
      check_val("rst_req_valid", imem_req_valid, 0);
      check_val("rst_instr_valid", instr_valid, 0);
      check_val("rst_instr", instr, NOP);
      check_val("rst_instr_pc", instr_pc, 0);
      memq.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_pc = RST_PC; exp_req = RST_PC;
      accs = 0; pops = 0; got_first = 1'b0;
   endtask

   initial begin
      redir_target = '0;
      // Cold start, full throughput with a one-cycle memory.
      do_reset();
      drive(1, 1, 1);
      for (int c = 1; c <= 8; c++) begin
         cycle();
         check_val("t1_req_fire", o_fire, 1);
         check_val("t1_instr_valid", o_iv, (c >= 3));
      end
      check_val("t1_pops", pops, 6);

      // Decoder stalled: the credit limit caps accepted requests.
      do_reset();
      drive(1, 1, 0);
      repeat (10) cycle();
      check_val("t2_accs", accs, DEPTH);
      check_val("t2_req_valid", o_rv, 0);
      check_val("t2_instr_valid", o_iv, 1);
      check_val("t2_head_pc", o_ipc, 32'h0);
      drive(1, 1, 1);
      repeat (3) cycle();
      check_val("t2_first_pop", first_pop, 32'h0);

      // Redirect with two requests in flight.
      do_reset();
      drive(1, 0, 1);
      repeat (3) begin
         if (accs == DEPTH) begin want_redir = 1'b1; redir_target = 32'h100; end
         cycle();
      end
      check_val("t3_accs", accs, 2);
      drive(1, 1, 1);
      repeat (10) cycle();
      check_val("t3_got_first", got_first, 1);
      check_val("t3_first_pop", first_pop, 32'h100);

      // Redirect coinciding with a response and an accept.
      do_reset();
      drive(1, 1, 0);
      cycle();
      want_redir = 1'b1; redir_target = 32'h100;
      cycle();
      check_val("t4_acc_in_redirect", o_fire, 1);
      cycle();
      check_val("t4_next_req_fire", o_fire, 1);
      check_val("t4_next_req_addr", o_addr, 32'h100);
      drive(1, 1, 1);
      repeat (6) cycle();
      check_val("t4_first_pop", first_pop, 32'h100);

      // Unaligned redirect target.
      do_reset();
      drive(0, 1, 1);
      want_redir = 1'b1; redir_target = 32'h203;
      cycle();
      drive(1, 1, 1);
      cycle();
      check_val("t5_req_valid", o_rv, 1);
      check_val("t5_req_addr", o_addr, 32'h200);
      repeat (6) cycle();
      check_val("t5_first_pop", first_pop, 32'h200);

      // Random traffic, each block entered through a mid-stream reset.
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int c = 0; c < 700; c++) begin
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 3) begin
               want_redir = 1'b1;
               redir_target = (blk == 3) ? $urandom : ($urandom & 32'h0000_0FFF);
            end
            cycle();
            if (c == 0) begin
               check_val("refetch_valid", o_rv, 1);
               check_val("refetch_addr", o_addr, RST_PC);
            end
         end
         check_val("rand_progress", 64'(pops > 50), 64'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
